// File: rtl/hft_pkg.sv
// Shared definitions for the risk request path.
// - state_e : arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
// - TRADE_W : native trade word width
package hft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int TRADE_W = 32;

endpackage

// File: rtl/risk_request_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
// Ports:
//   req       in  N      live request vector
//   ptr       in  PTR_W  index with highest priority this round
//   grant     out N      one-hot grant (all zero when nothing requests)
//   grant_idx out PTR_W  binary index of the granted requester
//   grant_any out 1      at least one request is live
// The pointer itself is owned by the parent so it only advances on a completed trade.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             grant_any
);

  int               scan_idx;
  logic [PTR_W-1:0] scan_sel;

  // Scan upward from the pointer, wrapping modulo N; the first live request wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    scan_idx  = 0;
    scan_sel  = '0;
    for (int k = 0; k < N; k++) begin
      scan_idx = int'(ptr) + k;
      if (scan_idx >= N) begin
        scan_idx = scan_idx - N;
      end else begin
        scan_idx = scan_idx;
      end
      scan_sel = PTR_W'(scan_idx);
      if (!grant_any && req[scan_sel]) begin
        grant[scan_sel] = 1'b1;
        grant_idx       = scan_sel;
        grant_any       = 1'b1;
      end else begin
        grant_any = grant_any;
      end
    end
  end

endmodule

// File: rtl/risk_request_arbiter.sv
// risk_request_arbiter: shares one risk_management check port between NUM_REQ
// strategy engines, one trade in flight, round-robin fairness.
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   trade_enable    global kill switch, sampled at grant time
//   req_valid/data  per-requester request and trade word (slice i at i*DATA_W)
//   req_ready       one-hot accept pulse
//   resp_valid      one-hot verdict pulse to the granted requester
//   resp_approved   verdict, meaningful only with resp_valid
//   trade_data/valid  towards risk_management (valid is a single-cycle pulse)
//   trade_approved  verdict from risk_management, RISK_LATENCY cycles after trade_valid
//   busy            high whenever the FSM is not IDLE
//   approved_cnt / rejected_cnt  saturating statistics
// All outputs are registered. The grant is decided in IDLE and req_ready is shown
// in the following IDLE cycle, which is where the handshake completes.
module risk_request_arbiter
  import hft_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = TRADE_W,
  parameter int RISK_LATENCY = 1,
  parameter int CNT_W        = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      trade_enable,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic                      resp_approved,
  output logic [DATA_W-1:0]         trade_data,
  output logic                      trade_valid,
  input  logic                      trade_approved,
  output logic                      busy,
  output logic [CNT_W-1:0]          approved_cnt,
  output logic [CNT_W-1:0]          rejected_cnt
);

  localparam int                 PTR_W    = $clog2(NUM_REQ);
  localparam logic [3:0]         LAT      = 4'(RISK_LATENCY);
  localparam logic [PTR_W-1:0]   LAST_IDX = PTR_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     gnt_idx_q, gnt_idx_d;
  logic                 en_q, en_d;
  logic                 verdict_q, verdict_d;
  logic [3:0]           wcnt_q, wcnt_d;
  logic [3:0]           wcnt_dec;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [DATA_W-1:0]    data_sel;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic                 trade_valid_q, trade_valid_d;
  logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
  logic                 resp_approved_q, resp_approved_d;
  logic                 busy_q, busy_d;
  logic [CNT_W-1:0]     approved_cnt_q, approved_cnt_d;
  logic [CNT_W-1:0]     rejected_cnt_q, rejected_cnt_d;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [PTR_W-1:0]     arb_idx;
  logic                 arb_any;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_any (arb_any)
  );

  assign wcnt_dec = wcnt_q - 4'd1;

  // Select the trade word of the requester the arbiter is currently picking.
  always_comb begin
    data_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        data_sel = req_data[i*DATA_W +: DATA_W];
      end else begin
        data_sel = data_sel;
      end
    end
  end

  // Next-state and registered-output logic of the arbitration FSM.
  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    gnt_idx_d       = gnt_idx_q;
    en_d            = en_q;
    verdict_d       = verdict_q;
    wcnt_d          = wcnt_q;
    data_d          = data_q;
    req_ready_d     = '0;
    trade_valid_d   = 1'b0;
    resp_valid_d    = '0;
    resp_approved_d = 1'b0;
    approved_cnt_d  = approved_cnt_q;
    rejected_cnt_d  = rejected_cnt_q;
    case (state_q)
      IDLE: begin
        if (req_ready_q != '0) begin
          // Handshake cycle: the grant is consumed now, leave IDLE.
          verdict_d     = 1'b0;
          trade_valid_d = en_q;
          if (en_q) begin
            state_d = ISSUE;
          end else begin
            state_d = RESP;
          end
        end else if (arb_any) begin
          req_ready_d = arb_grant;
          gnt_idx_d   = arb_idx;
          data_d      = data_sel;
          en_d        = trade_enable;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        // trade_valid is visible in this cycle; a zero-latency checker answers now.
        if (LAT == 4'd0) begin
          verdict_d = trade_approved;
          state_d   = RESP;
        end else begin
          wcnt_d  = LAT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        wcnt_d = wcnt_dec;
        if (wcnt_dec == 4'd0) begin
          verdict_d = trade_approved;
          state_d   = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        resp_valid_d    = ONE_HOT0 << gnt_idx_q;
        resp_approved_d = verdict_q;
        if (verdict_q) begin
          approved_cnt_d = sat_inc(approved_cnt_q);
        end else begin
          rejected_cnt_d = sat_inc(rejected_cnt_q);
        end
        if (gnt_idx_q == LAST_IDX) begin
          ptr_d = '0;
        end else begin
          ptr_d = gnt_idx_q + PTR_W'(1);
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, latches and registered outputs; reset drops any trade in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      ptr_q           <= '0;
      gnt_idx_q       <= '0;
      en_q            <= 1'b0;
      verdict_q       <= 1'b0;
      wcnt_q          <= 4'd0;
      data_q          <= '0;
      req_ready_q     <= '0;
      trade_valid_q   <= 1'b0;
      resp_valid_q    <= '0;
      resp_approved_q <= 1'b0;
      busy_q          <= 1'b0;
      approved_cnt_q  <= '0;
      rejected_cnt_q  <= '0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      gnt_idx_q       <= gnt_idx_d;
      en_q            <= en_d;
      verdict_q       <= verdict_d;
      wcnt_q          <= wcnt_d;
      data_q          <= data_d;
      req_ready_q     <= req_ready_d;
      trade_valid_q   <= trade_valid_d;
      resp_valid_q    <= resp_valid_d;
      resp_approved_q <= resp_approved_d;
      busy_q          <= busy_d;
      approved_cnt_q  <= approved_cnt_d;
      rejected_cnt_q  <= rejected_cnt_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_approved = resp_approved_q;
  assign trade_data    = data_q;
  assign trade_valid   = trade_valid_q;
  assign busy          = busy_q;
  assign approved_cnt  = approved_cnt_q;
  assign rejected_cnt  = rejected_cnt_q;

endmodule

// File: tb/tb_risk_request_arbiter.sv
// Self-checking bench for risk_request_arbiter (NUM_REQ=4, RISK_LATENCY=1, CNT_W=4).
// The reference is transaction level: a pending-request table, a round-robin pointer
// integer, a threshold risk rule and saturating integer counters.
module tb_risk_request_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 32;
  localparam int LAT = 1;
  localparam int CW  = 4;
  localparam logic [31:0] LIMIT = 32'h0040_0000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              trade_enable = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     resp_valid;
  logic              resp_approved;
  logic [DW-1:0]     trade_data;
  logic              trade_valid;
  logic              trade_approved = 1'b0;
  logic              busy;
  logic [CW-1:0]     approved_cnt;
  logic [CW-1:0]     rejected_cnt;

  risk_request_arbiter #(
    .NUM_REQ(NR), .DATA_W(DW), .RISK_LATENCY(LAT), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .trade_enable(trade_enable),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_approved(resp_approved),
    .trade_data(trade_data), .trade_valid(trade_valid),
    .trade_approved(trade_approved), .busy(busy),
    .approved_cnt(approved_cnt), .rejected_cnt(rejected_cnt)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          m_ptr = 0;
  int          m_appr = 0;
  int          m_rej = 0;
  bit          pend[NR];
  logic [31:0] pdata[NR];
  int          served0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_data();
    case ($urandom_range(7, 0))
      0:       rand_data = LIMIT;
      1:       rand_data = LIMIT + 32'd1;
      default: rand_data = 32'($urandom_range(32'h0080_0000, 0));
    endcase
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]          = pend[i];
      req_data[i*DW +: DW]  = pdata[i];
    end
  endtask

  // New requests get fresh data; requesters absent from vec withdraw (legal before grant).
  task automatic set_reqs(input logic [NR-1:0] vec);
    for (int i = 0; i < NR; i++) begin
      if (vec[i] && !pend[i]) begin
        pend[i]  = 1'b1;
        pdata[i] = rand_data();
      end else if (!vec[i]) begin
        pend[i] = 1'b0;
      end
    end
    drive();
  endtask

  function automatic int pick();
    pick = -1;
    for (int k = NR - 1; k >= 0; k--) begin
      if (pend[(m_ptr + k) % NR]) pick = (m_ptr + k) % NR;
    end
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) pend[i] = 1'b0;
    drive();
    trade_enable   = 1'b1;
    trade_approved = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    m_ptr  = 0;
    m_appr = 0;
    m_rej  = 0;
  endtask

  // One complete transaction; called while the DUT idles with requests already driven.
  task automatic do_trade(input bit en, output int g);
    logic [31:0]   d;
    logic [NR-1:0] oh;
    bit            ok;
    trade_enable = en;
    g  = pick();
    d  = pdata[g];
    oh = NR'(1) << g;
    ok = en && (d <= LIMIT);
    tick();
    trade_enable = 1'($urandom_range(1, 0));
    chk("req_ready", req_ready, oh);
    chk("busy_at_accept", busy, 1'b0);
    tick();
    pend[g] = 1'b0;
    drive();
    chk("req_ready_pulse", req_ready, '0);
    if (en) begin
      for (int j = 0; j <= LAT; j++) begin
        trade_approved = (j == LAT) ? ok : 1'($urandom_range(1, 0));
        chk("trade_valid", trade_valid, (j == 0));
        if (j == 0) chk("trade_data", trade_data, d);
        chk("busy_inflight", busy, 1'b1);
        chk("resp_early", resp_valid, '0);
        tick();
      end
      trade_approved = 1'($urandom_range(1, 0));
      chk("resp_early", resp_valid, '0);
      tick();
    end else begin
      chk("trade_valid_killed", trade_valid, 1'b0);
      chk("resp_early", resp_valid, '0);
      tick();
    end
    if (ok) m_appr = (m_appr < 15) ? m_appr + 1 : 15;
    else    m_rej  = (m_rej  < 15) ? m_rej  + 1 : 15;
    m_ptr = (g + 1) % NR;
    chk("resp_valid", resp_valid, oh);
    chk("resp_approved", resp_approved, ok);
    chk("approved_cnt", approved_cnt, m_appr);
    chk("rejected_cnt", rejected_cnt, m_rej);
  endtask

  initial begin
    int g;
    int order[5];
    for (int i = 0; i < NR; i++) begin
      pend[i]  = 1'b0;
      pdata[i] = 32'd0;
    end
    // Reset values
    #2;
    chk("rst_req_ready", req_ready, '0);
    chk("rst_resp_valid", resp_valid, '0);
    chk("rst_trade_valid", trade_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_counts", {approved_cnt, rejected_cnt}, '0);
    do_reset();

    // Single request, approved
    pend[0]  = 1'b1;
    pdata[0] = 32'h0001_0000;
    drive();
    do_trade(1'b1, g);
    chk("single_grant", g, 0);
    chk("single_appr_cnt", approved_cnt, 4'd1);

    // All four requesting continuously
    do_reset();
    order = '{0, 1, 2, 3, 0};
    for (int t = 0; t < 5; t++) begin
      set_reqs(4'hF);
      do_trade(1'b1, g);
      chk("all4_order", g, order[t]);
    end

    // Kill switch
    set_reqs(4'b0100);
    do_trade(1'b0, g);
    chk("kill_grant", g, 2);

    // Pointer wrap: pointer now 3, requesters 0 and 3 both pending
    served0 = 0;
    for (int t = 0; t < 8; t++) begin
      set_reqs(4'b1001);
      do_trade(1'b1, g);
      if (g == 0) served0++;
    end
    chk("wrap_r0_served", served0, 4);

    // Randomised traffic
    for (int t = 0; t < 40; t++) begin
      set_reqs(NR'($urandom_range(15, 1)));
      do_trade(($urandom_range(3, 0) != 0), g);
    end

    // Reset during WAIT: move the pointer to 2 first
    set_reqs(4'b0010);
    do_trade(1'b1, g);
    set_reqs(4'b0100);
    trade_enable = 1'b1;
    tick();
    tick();
    pend[2] = 1'b0;
    drive();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req_ready", req_ready, '0);
    chk("rst_mid_resp_valid", resp_valid, '0);
    chk("rst_mid_trade", {trade_valid, trade_data}, '0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_counts", {approved_cnt, rejected_cnt}, '0);
    tick();
    rst_n = 1'b1;
    m_ptr = 0; m_appr = 0; m_rej = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("rst_mid_no_resp", resp_valid, '0);
    end
    set_reqs(4'hF);
    do_trade(1'b1, g);
    chk("rst_mid_grant0", g, 0);

    // Counter saturation at 4'hF
    do_reset();
    for (int t = 0; t < 20; t++) begin
      pend[1]  = 1'b1;
      pdata[1] = 32'($urandom_range(32'h0040_0000, 0));
      drive();
      do_trade(1'b1, g);
    end
    chk("sat_approved", approved_cnt, 4'hF);
    chk("sat_rejected", rejected_cnt, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
